// File: rtl/osd_text_writer.sv
// ----------------------------------------------------------------------------
// osd_text_writer
//
// Turns a byte stream of characters and control codes into tile-RAM writes
// for an on-screen-display text layer.  Keeps a text cursor, handles CR, LF,
// BS and FF, and runs a full-screen clear sweep (4096 writes) on FF.
//
// Optional feature (compile-time macro OSD_AUTOCLR_EN):
//   When defined, every row advance (LF, or wrap off the last column) also
//   clears the full 128-entry row the cursor moves onto.  That sweep runs in
//   state CLR_ROW.  When the macro is undefined, CLR_ROW does not exist and a
//   row advance only moves the cursor.
//
// Parameters:
//   COLS  visible text columns (1..128)
//   ROWS  visible text rows    (1..32)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   cmd_valid  in   command byte present
//   cmd_ready  out  command accepted when cmd_valid && cmd_ready
//   cmd_data   in   [7] reverse attribute, [6:0] ASCII or control code
//   set_cur    in   one-cycle pulse loading the cursor (IDLE only)
//   cur_x_in   in   cursor column to load (clamped to COLS-1)
//   cur_y_in   in   cursor row to load (clamped to ROWS-1)
//   xt, yt     out  tile-RAM write column / row (registered)
//   ch_out     out  tile-RAM write data (registered)
//   we_ch      out  tile-RAM write enable (registered)
//   cur_x/y    out  current cursor position
//   busy       out  high while a clear sweep runs
// ----------------------------------------------------------------------------
module osd_text_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       set_cur,
  input  logic [6:0] cur_x_in,
  input  logic [4:0] cur_y_in,
  output logic [6:0] xt,
  output logic [4:0] yt,
  output logic [7:0] ch_out,
  output logic       we_ch,
  output logic [6:0] cur_x,
  output logic [4:0] cur_y,
  output logic       busy
);

  localparam logic [6:0] XMAX = 7'(COLS - 1);
  localparam logic [4:0] YMAX = 5'(ROWS - 1);

  localparam logic [6:0] C_BS = 7'h08;
  localparam logic [6:0] C_LF = 7'h0A;
  localparam logic [6:0] C_FF = 7'h0C;
  localparam logic [6:0] C_CR = 7'h0D;

`ifdef OSD_AUTOCLR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, CLR_ALL = 2'd1, CLR_ROW = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CLR_ALL = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [6:0]  cur_x_q, cur_x_d;
  logic [4:0]  cur_y_q, cur_y_d;
  logic [11:0] cnt_q, cnt_d;
  logic [6:0]  xt_q, xt_d;
  logic [4:0]  yt_q, yt_d;
  logic [7:0]  ch_q, ch_d;
  logic        we_q, we_d;

  logic [6:0]  code;
  logic        is_ctrl;
  logic        accept;
  logic        row_adv;

  function automatic logic [4:0] next_row(input logic [4:0] y);
    return (y == YMAX) ? 5'd0 : y + 5'd1;
  endfunction

  function automatic logic [6:0] clamp_x(input logic [6:0] x);
    return (x > XMAX) ? XMAX : x;
  endfunction

  function automatic logic [4:0] clamp_y(input logic [4:0] y);
    return (y > YMAX) ? YMAX : y;
  endfunction

  assign code      = cmd_data[6:0];
  // Bit 7 set turns any code, including control values, into a printable.
  assign is_ctrl   = !cmd_data[7] &&
                     ((code == C_BS) || (code == C_LF) || (code == C_FF) || (code == C_CR));
  assign cmd_ready = (state_q == IDLE) && !set_cur;
  assign accept    = cmd_valid && cmd_ready;
  assign row_adv   = accept && ((!is_ctrl && (cur_x_q == XMAX)) || (is_ctrl && (code == C_LF)));

  assign busy   = (state_q != IDLE);
  assign cur_x  = cur_x_q;
  assign cur_y  = cur_y_q;
  assign xt     = xt_q;
  assign yt     = yt_q;
  assign ch_out = ch_q;
  assign we_ch  = we_q;

  // ---- state register + datapath registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cur_x_q <= '0;
      cur_y_q <= '0;
      cnt_q   <= '0;
      xt_q    <= '0;
      yt_q    <= '0;
      ch_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      cnt_q   <= cnt_d;
      xt_q    <= xt_d;
      yt_q    <= yt_d;
      ch_q    <= ch_d;
      we_q    <= we_d;
    end
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && is_ctrl && (code == C_FF)) begin
          state_d = CLR_ALL;
        end
`ifdef OSD_AUTOCLR_EN
        else if (row_adv) begin
          state_d = CLR_ROW;
        end
`endif
      end
      CLR_ALL: begin
        if (cnt_q == 12'hFFF) state_d = IDLE;
      end
`ifdef OSD_AUTOCLR_EN
      CLR_ROW: begin
        if (cnt_q[6:0] == 7'h7F) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---- output / datapath logic ----
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    cnt_d   = cnt_q;
    xt_d    = xt_q;
    yt_d    = yt_q;
    ch_d    = ch_q;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        // Any sweep starts from count 0 on the cycle after it is entered.
        cnt_d = '0;
        if (set_cur) begin
          cur_x_d = clamp_x(cur_x_in);
          cur_y_d = clamp_y(cur_y_in);
        end else if (accept) begin
          if (!is_ctrl) begin
            we_d = 1'b1;
            xt_d = cur_x_q;
            yt_d = cur_y_q;
            ch_d = cmd_data;
            if (row_adv) begin
              cur_x_d = '0;
              cur_y_d = next_row(cur_y_q);
            end else begin
              cur_x_d = cur_x_q + 7'd1;
            end
          end else begin
            case (code)
              C_CR: cur_x_d = '0;
              C_LF: begin
                cur_x_d = '0;
                cur_y_d = next_row(cur_y_q);
              end
              C_BS: begin
                if (cur_x_q != 7'd0) begin
                  cur_x_d = cur_x_q - 7'd1;
                  we_d    = 1'b1;
                  xt_d    = cur_x_q - 7'd1;
                  yt_d    = cur_y_q;
                  ch_d    = 8'h00;
                end
              end
              default: ;
            endcase
          end
        end
      end
      CLR_ALL: begin
        // Count walks the whole 128x32 tile space; row in [11:7], column in [6:0].
        we_d  = 1'b1;
        xt_d  = cnt_q[6:0];
        yt_d  = cnt_q[11:7];
        ch_d  = 8'h00;
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == 12'hFFF) begin
          cur_x_d = '0;
          cur_y_d = '0;
        end
      end
`ifdef OSD_AUTOCLR_EN
      CLR_ROW: begin
        // Cursor already sits on the new row; clear all 128 tile columns of it.
        we_d  = 1'b1;
        xt_d  = cnt_q[6:0];
        yt_d  = cur_y_q;
        ch_d  = 8'h00;
        cnt_d = cnt_q + 12'd1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_osd_text_writer.sv
module tb_osd_text_writer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       set_cur;
  logic [6:0] cur_x_in;
  logic [4:0] cur_y_in;
  logic [6:0] xt;
  logic [4:0] yt;
  logic [7:0] ch_out;
  logic       we_ch;
  logic [6:0] cur_x;
  logic [4:0] cur_y;
  logic       busy;

  osd_text_writer #(.COLS(80), .ROWS(30)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .set_cur(set_cur), .cur_x_in(cur_x_in), .cur_y_in(cur_y_in),
    .xt(xt), .yt(yt), .ch_out(ch_out), .we_ch(we_ch),
    .cur_x(cur_x), .cur_y(cur_y), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  localparam int OP_IDLE = 0;
  localparam int OP_CMD  = 1;
  localparam int OP_SET  = 2;

  typedef struct {
    int         op;
    logic [7:0] d;
    logic [6:0] sx;
    logic [4:0] sy;
    logic       we;
    logic [6:0] ext;
    logic [4:0] eyt;
    logic [7:0] ech;
    logic [6:0] ecx;
    logic [4:0] ecy;
  } vec_t;

  function automatic vec_t mk(int op, logic [7:0] d, logic [6:0] sx, logic [4:0] sy,
                              logic we, logic [6:0] ext, logic [4:0] eyt, logic [7:0] ech,
                              logic [6:0] ecx, logic [4:0] ecy);
    vec_t v;
    v.op = op; v.d = d; v.sx = sx; v.sy = sy;
    v.we = we; v.ext = ext; v.eyt = eyt; v.ech = ech; v.ecx = ecx; v.ecy = ecy;
    return v;
  endfunction

  vec_t vecs[$];
  logic [4095:0] seen;
  int busy_cyc, writes, dup_err, data_err, ready_err, late_we;
  bit found;

  initial begin
    // Directed vectors, COLS=80 ROWS=30, starting from cursor (0,0) after reset.
    //              op       data   sx  sy   we  xt  yt  ch    cx  cy
    vecs.push_back(mk(OP_CMD,  8'h41, 0,  0,  1,  0,  0, 8'h41, 1,  0));
    vecs.push_back(mk(OP_CMD,  8'h42, 0,  0,  1,  1,  0, 8'h42, 2,  0));
    vecs.push_back(mk(OP_IDLE, 8'h00, 0,  0,  0,  1,  0, 8'h42, 2,  0));
    vecs.push_back(mk(OP_CMD,  8'h0D, 0,  0,  0,  1,  0, 8'h42, 0,  0));
    vecs.push_back(mk(OP_CMD,  8'h0A, 0,  0,  0,  1,  0, 8'h42, 0,  1));
    vecs.push_back(mk(OP_SET,  8'h00, 5,  3,  0,  1,  0, 8'h42, 5,  3));
    vecs.push_back(mk(OP_CMD,  8'h08, 0,  0,  1,  4,  3, 8'h00, 4,  3));
    vecs.push_back(mk(OP_SET,  8'h00, 0,  3,  0,  4,  3, 8'h00, 0,  3));
    vecs.push_back(mk(OP_CMD,  8'h08, 0,  0,  0,  4,  3, 8'h00, 0,  3));
    vecs.push_back(mk(OP_SET,  8'h00, 79, 29, 0,  4,  3, 8'h00, 79, 29));
    vecs.push_back(mk(OP_CMD,  8'hC2, 0,  0,  1,  79, 29, 8'hC2, 0,  0));
    vecs.push_back(mk(OP_SET,  8'h00, 127,31, 0,  79, 29, 8'hC2, 79, 29));
    vecs.push_back(mk(OP_CMD,  8'h8D, 0,  0,  1,  79, 29, 8'h8D, 0,  0));
    vecs.push_back(mk(OP_SET,  8'h00, 10, 29, 0,  79, 29, 8'h8D, 10, 29));
    vecs.push_back(mk(OP_CMD,  8'h0A, 0,  0,  0,  79, 29, 8'h8D, 0,  0));
    vecs.push_back(mk(OP_CMD,  8'h7F, 0,  0,  1,  0,  0, 8'h7F, 1,  0));
    vecs.push_back(mk(OP_CMD,  8'h88, 0,  0,  1,  1,  0, 8'h88, 2,  0));
    vecs.push_back(mk(OP_SET,  8'h00, 78, 5,  0,  1,  0, 8'h88, 78, 5));
    vecs.push_back(mk(OP_CMD,  8'h20, 0,  0,  1,  78, 5, 8'h20, 79, 5));
    vecs.push_back(mk(OP_CMD,  8'h21, 0,  0,  1,  79, 5, 8'h21, 0,  6));
    vecs.push_back(mk(OP_CMD,  8'h8A, 0,  0,  1,  0,  6, 8'h8A, 1,  6));

    reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
    set_cur = 1'b0; cur_x_in = '0; cur_y_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we_ch, 0);
    chk("rst_xt", xt, 0);
    chk("rst_yt", yt, 0);
    chk("rst_ch", ch_out, 0);
    chk("rst_cx", cur_x, 0);
    chk("rst_cy", cur_y, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    reset = 1'b0;

    // ---- table-driven single-cycle commands ----
    foreach (vecs[i]) begin
      cmd_valid = (vecs[i].op == OP_CMD);
      cmd_data  = vecs[i].d;
      set_cur   = (vecs[i].op == OP_SET);
      cur_x_in  = vecs[i].sx;
      cur_y_in  = vecs[i].sy;
      #1;
      if (vecs[i].op == OP_SET) chk($sformatf("v%0d_ready_setcur", i), cmd_ready, 0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      set_cur   = 1'b0;
      chk($sformatf("v%0d_we", i), we_ch, vecs[i].we);
      chk($sformatf("v%0d_xt", i), xt, vecs[i].ext);
      chk($sformatf("v%0d_yt", i), yt, vecs[i].eyt);
      chk($sformatf("v%0d_ch", i), ch_out, vecs[i].ech);
      chk($sformatf("v%0d_cx", i), cur_x, vecs[i].ecx);
      chk($sformatf("v%0d_cy", i), cur_y, vecs[i].ecy);
    end

    // ---- full-screen clear (FF) ----
    cmd_valid = 1'b1; cmd_data = 8'h0C;
    @(posedge clk);
    #1;
    chk("ff_busy_start", busy, 1);
    chk("ff_no_write_on_accept", we_ch, 0);
    chk("ff_ready_low_start", cmd_ready, 0);
    // Keep pressure on both inputs; neither may be taken during the sweep.
    cmd_data = 8'h55; set_cur = 1'b1; cur_x_in = 7'd9; cur_y_in = 5'd9;
    seen = '0;
    busy_cyc = 1; writes = 0; dup_err = 0; data_err = 0; ready_err = 0;
    for (int c = 0; c < 5000 && busy; c++) begin
      @(posedge clk);
      #1;
      if (we_ch) begin
        writes++;
        if (ch_out !== 8'h00) data_err++;
        if (seen[{yt, xt}]) dup_err++;
        seen[{yt, xt}] = 1'b1;
      end
      if (busy) begin
        busy_cyc++;
        if (cmd_ready) ready_err++;
      end
    end
    cmd_valid = 1'b0; set_cur = 1'b0;
    chk("ff_timeout", busy, 0);
    chk("ff_busy_cycles", busy_cyc, 4096);
    chk("ff_writes", writes, 4096);
    chk("ff_duplicates", dup_err, 0);
    chk("ff_all_covered", &seen, 1);
    chk("ff_data_zero", data_err, 0);
    chk("ff_ready_low", ready_err, 0);
    chk("ff_cx", cur_x, 0);
    chk("ff_cy", cur_y, 0);
    @(posedge clk);
    #1;
    chk("ff_after_we", we_ch, 0);
    chk("ff_after_ready", cmd_ready, 1);
    chk("ff_after_cx", cur_x, 0);

    // ---- reset in the middle of a clear sweep ----
    set_cur = 1'b1; cur_x_in = 7'd3; cur_y_in = 5'd4;
    @(posedge clk);
    #1;
    set_cur = 1'b0;
    chk("mid_setcur_cx", cur_x, 3);
    cmd_valid = 1'b1; cmd_data = 8'h0C;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      @(posedge clk);
      #1;
      if (we_ch && ({yt, xt} == 12'd100)) found = 1'b1;
    end
    chk("mid_reached_100", found, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_we_drop", we_ch, 0);
    chk("mid_cx", cur_x, 0);
    chk("mid_cy", cur_y, 0);
    chk("mid_busy", busy, 0);
    chk("mid_xt", xt, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_ready_after", cmd_ready, 1);
    late_we = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (we_ch) late_we++;
    end
    chk("mid_no_more_writes", late_we, 0);
    chk("mid_idle_after", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_text_writer.md
OSD_TEXT_WRITER -- requirements
Module: osd_text_writer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning visible text columns (1..128).
REQ-002 SHALL have parameter ROWS, default 30, meaning visible text rows (1..32).
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command byte present.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-008 SHALL have port cmd_data  input  8  bit7 = reverse attribute; [6:0] = ASCII or control code.
REQ-009 SHALL have port set_cur  input  1  one-cycle pulse loading the cursor.
REQ-010 SHALL have port cur_x_in  input  7  cursor column to load.
REQ-011 SHALL have port cur_y_in  input  5  cursor row to load.
REQ-012 SHALL have port xt  output  7  tile-RAM write column.
REQ-013 SHALL have port yt  output  5  tile-RAM write row.
REQ-014 SHALL have port ch_out  output  8  tile-RAM write data.
REQ-015 SHALL have port we_ch  output  1  tile-RAM write enable.
REQ-016 SHALL have ports cur_x  output  7 and cur_y  output  5  current cursor position.
REQ-017 SHALL have port busy  output  1  high while a clear sweep runs.

Function
REQ-018 SHALL use FSM states IDLE, CLR_ALL, CLR_ROW; cmd_ready = (state==IDLE) && !set_cur.
REQ-019 SHALL register xt, yt, ch_out and we_ch, so a write appears exactly 1 cycle after acceptance.
REQ-020 SHALL treat a command with cmd_data[7]==0 and [6:0] in {0x08, 0x0A, 0x0C, 0x0D} as control; all other values are printable.
REQ-021 Printable: SHALL write cmd_data at (cur_x,cur_y), then advance cur_x; at cur_x==COLS-1, cur_x->0 and do a row advance.
REQ-022 Row advance: cur_y+1; at cur_y==ROWS-1, cur_y->0 (wrap to top).
REQ-023 0x0D (CR): SHALL set cur_x=0, with no write.
REQ-024 0x0A (LF): SHALL set cur_x=0 and do a row advance, with no write.
REQ-025 0x08 (BS): if cur_x>0, SHALL decrement cur_x and write 0x00 at the new position; if cur_x==0, no-op and no write.
REQ-026 0x0C (FF): SHALL enter CLR_ALL and write 0x00 to all 4096 addresses; xt = count[6:0], yt = count[11:7], one per cycle, count 0..4095.
REQ-027 At the end of CLR_ALL, SHALL set the cursor to (0,0) and return to IDLE.
REQ-028 set_cur in IDLE: SHALL load the cursor, clamped to COLS-1 / ROWS-1, with no write; set_cur is ignored outside IDLE.
REQ-029 SHALL drive we_ch=0 whenever no write is issued; xt, yt and ch_out hold their last values.
REQ-030 SHALL drive busy=1 exactly while state != IDLE.

Reset
REQ-031 On reset SHALL asynchronously force state=IDLE, cursor=(0,0), xt=0, yt=0, ch_out=0, we_ch=0.
REQ-032 Reset during a sweep SHALL abort it with no further writes; tile RAM contents are not restored.

Configuration
REQ-033 With macro OSD_AUTOCLR_EN defined: every row advance SHALL enter CLR_ROW and write 0x00 to xt=0..127 of the new cur_y (128 cycles), then return to IDLE.
REQ-034 With OSD_AUTOCLR_EN defined, cmd_ready SHALL be low during CLR_ROW.
REQ-035 Without OSD_AUTOCLR_EN: CLR_ROW SHALL be absent, and a row advance only moves the cursor.

Verification
REQ-036 Reset, then send 'A' (0x41) -> one cycle later we_ch=1, xt=0, yt=0, ch_out=0x41; cur_x=1.
REQ-037 set_cur (COLS-1=79, 29), then send 0xC2 -> write at (79,29) with ch_out=0xC2; cursor goes to (0,0) (autoclr off).
REQ-038 Cursor at (5,3), send 0x08, then 0x08 with cursor at (0,3) -> first: write 0x00 at (4,3); second: no write, cursor unchanged.
REQ-039 Send 0x0C -> busy high for 4096 cycles, 4096 writes of 0x00 covering every address once, cmd_ready low throughout, cursor ends at (0,0).
REQ-040 With OSD_AUTOCLR_EN, cursor at (10,2), send 0x0A -> 128 writes of 0x00 at yt=3, xt=0..127; cursor ends at (0,3).
REQ-041 Assert reset at CLR_ALL count 100 -> we_ch drops immediately, cursor=(0,0), cmd_ready=1 after reset release.
